// File: rtl/ldl_afifo_wr_arb_v1.sv
// ldl_afifo_wr_arb_v1: round-robin burst write arbiter for the async FIFO write port
module ldl_afifo_wr_arb_v1 #(
  parameter int N = 4,
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int BURST = 4,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  input  logic            fifo_full,
  input  logic [AW:0]     fifo_wcnt,
  output logic            fifo_we,
  output logic [DW-1:0]   fifo_din,
  output logic [N-1:0]    gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            busy
);
  typedef enum logic {ST_IDLE, ST_BURST} state_t;
  localparam logic [AW:0] CAP = (AW+1)'(2**AW);
  localparam logic [AW:0] BW = (AW+1)'(BURST);
  localparam logic [AW:0] LAST = (AW+1)'(BURST-1);
  state_t state, state_nx;
  logic [N-1:0] gnt_nx;
  logic [IW-1:0] gnt_id_nx, ptr, ptr_nx, pick;
  logic [AW:0] cnt, cnt_nx, free;
  logic found;
  assign free = CAP - fifo_wcnt;
  assign busy = state == ST_BURST;
  // first valid requester scanning upward from the one after the last winner
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req_valid[IW'((int'(ptr) + k) % N)]) begin
        found = 1'b1;
        pick = IW'((int'(ptr) + k) % N);
      end
    end
  end
  // next state and the write-port outputs driven from the registered grant
  always_comb begin
    state_nx = state;
    gnt_nx = gnt;
    gnt_id_nx = gnt_id;
    cnt_nx = cnt;
    ptr_nx = ptr;
    req_ready = '0;
    fifo_we = 1'b0;
    fifo_din = '0;
    if (state == ST_IDLE) begin
      if (found && free >= BW) begin
        state_nx = ST_BURST;
        gnt_nx = N'(1) << pick;
        gnt_id_nx = pick;
        cnt_nx = '0;
      end
    end else begin
      req_ready = fifo_full ? '0 : N'(1) << gnt_id;
      fifo_we = req_valid[gnt_id] & ~fifo_full;
      fifo_din = req_data[int'(gnt_id)*DW +: DW];
      if (!req_valid[gnt_id] || (fifo_we && cnt == LAST)) begin
        state_nx = ST_IDLE;
        gnt_nx = '0;
        ptr_nx = gnt_id;
      end else if (fifo_we) begin
        cnt_nx = cnt + (AW+1)'(1);
      end
    end
  end
  // state register; pointer resets to N-1 so requester 0 wins first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      gnt <= '0;
      gnt_id <= '0;
      cnt <= '0;
      ptr <= IW'(N-1);
    end else begin
      state <= state_nx;
      gnt <= gnt_nx;
      gnt_id <= gnt_id_nx;
      cnt <= cnt_nx;
      ptr <= ptr_nx;
    end
  end
endmodule
